// File: rtl/sequence_detector_if.sv
// Serial bit-stream bundle for the 1-0-1 sequence detector.
// Handshake: no valid/ready pair; "in" carries one bit every clk cycle and is
// consumed on each rising edge, "out" is a same-cycle Mealy flag.
interface sequence_detector_if;
  logic in;
  logic out;

  // Stream source drives the bit and observes the detect flag.
  modport master (output in, input out);

  // Detector consumes the bit and produces the detect flag.
  modport slave (input in, output out);
endinterface

// File: rtl/sequence_detector.sv
// Mealy detector for the serial pattern 1-0-1.
// "out" is high in the cycle whose current input bit completes the pattern.
// Build option SEQ_DET_OVERLAP_EN: when defined, the completing 1 also starts
// the next pattern (overlapping detection); otherwise matching restarts from
// scratch after each hit.
module sequence_detector (
  input  logic in,
  output logic out,
  input  logic clk,
  input  logic rst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,  // no useful prefix seen
    S_1    = 2'b01,  // last bit was 1
    S_10   = 2'b10,  // last two bits were 1,0
    S_BAD  = 2'b11   // unused encoding, recovers to S_IDLE
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Mealy output decode.
  always_comb begin
    state_d = S_IDLE;
    out     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = in ? S_1 : S_IDLE;
      end
      S_1: begin
        state_d = in ? S_1 : S_10;
      end
      S_10: begin
        // The reset term keeps the flag quiet while the FSM is being cleared.
        out = in & ~rst;
`ifdef SEQ_DET_OVERLAP_EN
        // Completing 1 is reused as the first bit of the next pattern.
        state_d = in ? S_1 : S_IDLE;
`else
        // Completing 1 is consumed; matching starts over.
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
        out     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sequence_detector.sv
// Self-checking bench for sequence_detector: directed scenarios followed by
// random bit streams with occasional resets, compared against a history-based
// reference model. Honours SEQ_DET_OVERLAP_EN the same way as the design.
module tb_sequence_detector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sequence_detector_if bus ();

  sequence_detector dut (
    .in  (bus.in),
    .out (bus.out),
    .clk (clk),
    .rst (rst)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Bits received since the last reset or the last consumed match.
  bit hist_q[$];

  // Expected flag: the two bits before the current one were 1 then 0,
  // and the current bit is 1.
  function automatic logic model_hit(input logic b);
    if (hist_q.size() < 2) return 1'b0;
    return (hist_q[hist_q.size()-2] == 1'b1) &&
           (hist_q[hist_q.size()-1] == 1'b0) && (b == 1'b1);
  endfunction

  // Advance the model by one clock edge.
  function automatic void model_step(input logic b, input logic r);
    logic hit;
    if (r) begin
      hist_q.delete();
      return;
    end
    hit = model_hit(b);
`ifdef SEQ_DET_OVERLAP_EN
    hist_q.push_back(b);
`else
    if (hit) hist_q.delete();
    else     hist_q.push_back(b);
`endif
    while (hist_q.size() > 2) void'(hist_q.pop_front());
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one bit (and reset level) for one cycle, check out mid-cycle.
  task automatic drive_bit(input logic b, input logic r, input string tag);
    @(negedge clk);
    bus.in = b;
    rst    = r;
    #1;
    check(tag, bus.out, r ? 1'b0 : model_hit(b));
    @(posedge clk);
    model_step(b, r);
  endtask

  // Drive a short sequence given LSB-first in a vector.
  task automatic drive_seq(input logic [15:0] bits, input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      drive_bit(bits[i], 1'b0, tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in = 1'b0;

    // Reset held for two edges with in=0.
    drive_bit(1'b0, 1'b1, "reset_0");
    drive_bit(1'b0, 1'b1, "reset_1");

    // Basic detect: 0,0,1,0,1,1,1 (hit on 5th bit).
    drive_seq(16'b0000_0000_0111_0100, 7, "basic");

    // Flush, then 1,0,1,0,1 (overlap: hits at 3 and 5; otherwise 3 only).
    drive_bit(1'b0, 1'b1, "rst_pre_ovl");
    drive_seq(16'b0000_0000_0001_0101, 5, "overlap");

    // Reset mid-pattern: 1,0, reset with in=1, then 1, then 0,1.
    drive_bit(1'b0, 1'b1, "rst_pre_mid");
    drive_seq(16'b0000_0000_0000_0001, 2, "mid_prefix");
    drive_bit(1'b1, 1'b1, "mid_rst_in1");
    drive_seq(16'b0000_0000_0000_0101, 3, "mid_after");

    // Long runs of 1s and 0s never flag.
    drive_seq(16'hFFFF, 16, "ones_run");
    drive_seq(16'h0000, 16, "zeros_run");

    // Mealy timing: reach S_10 then toggle in 0->1 within one cycle.
    drive_seq(16'b0000_0000_0000_0001, 2, "mealy_prefix");
    @(negedge clk);
    rst    = 1'b0;
    bus.in = 1'b0;
    #1;
    check("mealy_low", bus.out, model_hit(1'b0));
    bus.in = 1'b1;
    #1;
    check("mealy_high", bus.out, model_hit(1'b1));
    @(posedge clk);
    model_step(1'b1, 1'b0);

    // Random streams with occasional resets.
    for (int i = 0; i < 500; i++) begin
      drive_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "random");
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
- REQ-001 SHALL have no parameters; the 2-bit state encoding is fixed internally.
- REQ-002 SHALL declare ports in this exact positional order: in, out, clk, rst.
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 rst  input  1  reset, synchronous, active-high; sampled on the rising clk edge.
- REQ-005 in  input  1  serial data bit, one bit per clk cycle, sampled on the rising edge.
- REQ-006 out  output  1  Mealy detect flag; high when the bit currently on in completes the pattern 1-0-1.

Function
- REQ-007 SHALL implement a Mealy FSM with states S_IDLE=2'b00 (no prefix), S_1=2'b01 (last bit 1), S_10=2'b10 (last bits 1,0).
- REQ-008 S_IDLE SHALL go to S_1 on in=1 and stay in S_IDLE on in=0.
- REQ-009 S_1 SHALL stay in S_1 on in=1 and go to S_10 on in=0.
- REQ-010 S_10 SHALL go to S_IDLE on in=0.
- REQ-011 S_10 on in=1 SHALL transition as set by REQ-019/REQ-020.
- REQ-012 out SHALL be purely combinational: out = (state==S_10) && in && !rst, with zero cycles of latency.
- REQ-013 out SHALL be high only for the cycle in which the final 1 is present, and SHALL be low in all other cycles.
- REQ-014 The unused encoding 2'b11 SHALL drive out=0 and SHALL go to S_IDLE on the next edge.
- REQ-015 A long run of 1s (1,1,1,...) SHALL never assert out.
- REQ-016 A run of 0s SHALL never assert out.

Reset
- REQ-017 rst=1 at a rising clk edge SHALL force state to S_IDLE, regardless of in or the current state, including mid-pattern.
- REQ-018 While rst=1, out SHALL be 0; the first cycle after rst deasserts starts from S_IDLE with no remembered prefix.

Configuration
- REQ-019 When macro SEQ_DET_OVERLAP_EN is defined, S_10 with in=1 SHALL go to S_1, so the final 1 is reused as the first bit of the next pattern (overlapping detection).
- REQ-020 When SEQ_DET_OVERLAP_EN is not defined, S_10 with in=1 SHALL go to S_IDLE (non-overlapping detection).
- REQ-021 All other behaviour SHALL be identical with or without SEQ_DET_OVERLAP_EN.

Verification
- REQ-022 Reset: rst=1 for 2 edges with in=0 -> state S_IDLE, out=0 throughout.
- REQ-023 Basic detect: after reset, drive in 0,0,1,0,1,1,1 (one bit per cycle) -> out=1 only in the cycle where the 5th bit (1) is present; 0 elsewhere.
- REQ-024 Overlap, macro defined: drive in 1,0,1,0,1 -> out=1 in cycles 3 and 5.
- REQ-025 Non-overlap, macro undefined: drive in 1,0,1,0,1 -> out=1 in cycle 3 only.
- REQ-026 Reset mid-pattern: drive in 1,0, assert rst for 1 edge, then drive in 1 -> out=0; a following 0,1 -> out=1 on that final 1.
- REQ-027 Mealy timing: in S_10, toggle in 0->1 between edges -> out follows in combinationally within the same cycle, before the next edge.
